// File: rtl/conv3x3_pipe.sv
// conv3x3_pipe: 3x3 masked convolution with loadable signed coefficients, round/shift/clamp, valid/ready pipeline
module conv3x3_pipe #(
    parameter int DATA_WIDTH  = 8,
    parameter int COEF_WIDTH  = 6,
    parameter int SHIFT_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [9*DATA_WIDTH-1:0] pix_in,
    input  logic [3:0]              corner_type,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   data_out,
    input  logic                    coef_we,
    input  logic [3:0]              coef_addr,
    input  logic [COEF_WIDTH-1:0]   coef_wdata,
    input  logic                    sat_clr,
    output logic [15:0]             sat_cnt
);
    localparam int PW = DATA_WIDTH + COEF_WIDTH + 1;
    localparam int RW = PW + 2;
    localparam int AW = DATA_WIDTH + COEF_WIDTH + 5;
    localparam logic signed [AW-1:0] MAXV = AW'((1 << DATA_WIDTH) - 1);

    function automatic logic signed [COEF_WIDTH-1:0] def_coef(input int k);
        return COEF_WIDTH'((k / 3 == 1 ? 2 : 1) * (k % 3 == 1 ? 2 : 1));
    endfunction

    function automatic logic tap_on(input logic [3:0] ct, input int k);
        int r;
        int c;
        r = k / 3;
        c = k % 3;
        return ct == 4'd0 ? 1'b0 :
               ct == 4'd1 ? (r < 2 && c < 2) :
               ct == 4'd2 ? (r < 2 && c > 0) :
               ct == 4'd3 ? (c < 2) :
               ct == 4'd4 ? (c > 0) :
               ct == 4'd5 ? (r > 0 && c < 2) :
               ct == 4'd6 ? (r > 0 && c > 0) : 1'b1;
    endfunction

    logic signed [COEF_WIDTH-1:0] r_coef [9];
    logic [SHIFT_WIDTH-1:0]       r_shift, r_shift1, r_shift2;
    logic                         r_rnd, r_rnd1, r_rnd2;
    logic                         r_v1, r_v2, r_v3, r_sat3, r_sato;
    logic signed [PW-1:0]         r_prod [9];
    logic signed [RW-1:0]         r_row [3];
    logic [DATA_WIDTH-1:0]        r_res3;
    logic signed [DATA_WIDTH:0]   w_px [9];
    logic signed [AW-1:0]         w_rnd, w_acc, w_sh;
    logic [DATA_WIDTH-1:0]        w_res;
    logic                         w_sat, w_adv;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    always_comb begin
        for (int k = 0; k < 9; k++)
            w_px[k] = tap_on(corner_type, k) ? {1'b0, pix_in[k*DATA_WIDTH +: DATA_WIDTH]} : '0;
        w_rnd = (r_rnd2 && |r_shift2) ? AW'(1) << (r_shift2 - SHIFT_WIDTH'(1)) : '0;
        w_acc = AW'(r_row[0]) + AW'(r_row[1]) + AW'(r_row[2]) + w_rnd;
        w_sh  = w_acc >>> r_shift2;
        w_sat = w_sh < 0 || w_sh > MAXV;
        w_res = w_sh < 0 ? '0 : w_sh > MAXV ? '1 : w_sh[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++)
                r_coef[k] <= def_coef(k);
            r_shift   <= SHIFT_WIDTH'(4);
            r_rnd     <= 1'b0;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_v3      <= 1'b0;
            r_res3    <= '0;
            r_sat3    <= 1'b0;
            r_sato    <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
            sat_cnt   <= '0;
        end else begin
            if (coef_we && coef_addr < 4'd9)
                r_coef[coef_addr] <= coef_wdata;
            else if (coef_we && coef_addr == 4'd9) begin
                r_shift <= coef_wdata[SHIFT_WIDTH-1:0];
                r_rnd   <= coef_wdata[SHIFT_WIDTH];
            end
            // every stage moves together, so bubbles travel as valid=0 slots
            if (w_adv) begin
                r_v1 <= in_valid;
                for (int k = 0; k < 9; k++)
                    r_prod[k] <= PW'(w_px[k]) * PW'(r_coef[k]);
                r_shift1 <= r_shift;
                r_rnd1   <= r_rnd;
                r_v2     <= r_v1;
                for (int r = 0; r < 3; r++)
                    r_row[r] <= RW'(r_prod[3*r]) + RW'(r_prod[3*r+1]) + RW'(r_prod[3*r+2]);
                r_shift2  <= r_shift1;
                r_rnd2    <= r_rnd1;
                r_v3      <= r_v2;
                r_res3    <= w_res;
                r_sat3    <= w_sat;
                out_valid <= r_v3;
                data_out  <= r_res3;
                r_sato    <= r_sat3;
            end
            if (sat_clr)
                sat_cnt <= '0;
            else if (out_valid && out_ready && r_sato && sat_cnt != 16'hFFFF)
                sat_cnt <= sat_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_conv3x3_pipe.sv
// tb_conv3x3_pipe: directed checks of conv3x3_pipe against hand-computed results
module tb_conv3x3_pipe;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [71:0] pix_in;
    logic [3:0]  corner_type, coef_addr;
    logic [7:0]  data_out;
    logic        coef_we, sat_clr;
    logic [5:0]  coef_wdata;
    logic [15:0] sat_cnt;
    int          total = 0;
    int          passed = 0;
    int          fails = 0;

    conv3x3_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .pix_in(pix_in), .corner_type(corner_type), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_wdata(coef_wdata), .sat_clr(sat_clr),
        .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] fill(input logic [7:0] v);
        logic [71:0] p;
        for (int k = 0; k < 9; k++)
            p[k*8 +: 8] = v;
        return p;
    endfunction

    // Gaussian weights with the border masks written out per corner code
    function automatic int model(input logic [71:0] p, input logic [3:0] ct);
        int s = 0;
        for (int k = 0; k < 9; k++) begin
            int  r = k / 3;
            int  c = k % 3;
            bit  on;
            case (ct)
                4'd0: on = 0;
                4'd1: on = (r <= 1) && (c <= 1);
                4'd2: on = (r <= 1) && (c >= 1);
                4'd3: on = (c <= 1);
                4'd4: on = (c >= 1);
                4'd5: on = (r >= 1) && (c <= 1);
                4'd6: on = (r >= 1) && (c >= 1);
                default: on = 1;
            endcase
            if (on) s += (r == 1 ? 2 : 1) * (c == 1 ? 2 : 1) * int'(p[k*8 +: 8]);
        end
        return s / 16;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [5:0] d);
        coef_we = 1'b1;
        coef_addr = a;
        coef_wdata = d;
        step();
        coef_we = 1'b0;
    endtask

    task automatic xfer(input logic [71:0] px, input logic [3:0] ct, input int exp, input string tag);
        int n = 0;
        pix_in = px;
        corner_type = ct;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        while (!out_valid && n < 10) begin
            step();
            n++;
        end
        chk({tag, "_v"}, out_valid, 1);
        chk(tag, data_out, exp);
        step();
    endtask

    initial begin
        logic [71:0] p;
        logic [95:0] rnd;
        int          sent, got, cyc;
        int          q[$];
        logic        hold;
        logic [7:0]  hd;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; pix_in = '0; corner_type = 4'd8;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; sat_clr = 1'b0;
        step();
        step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_sat_cnt", sat_cnt, 0);
        rst_n = 1'b1;
        step();

        pix_in = fill(8'd100);
        corner_type = 4'd8;
        in_valid = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 5) in_valid = 1'b0;
            chk("lat_valid", out_valid, (k >= 4 && k <= 8) ? 1 : 0);
            if (k >= 4 && k <= 8) chk("lat_data", data_out, 100);
        end
        chk("gauss_sat", sat_cnt, 0);

        xfer(fill(8'd100), 4'd1, 56, "corner1");
        xfer(fill(8'd100), 4'd0, 0, "corner0");
        chk("corner_sat", sat_cnt, 0);

        for (int k = 0; k < 9; k++)
            wr(4'(k), k == 4 ? 6'd8 : 6'h3F);
        wr(4'd9, 6'd0);
        xfer(fill(8'd50), 4'd8, 0, "lap_flat");
        chk("lap_flat_sat", sat_cnt, 0);
        p = fill(8'd50);
        p[32 +: 8] = 8'd0;
        xfer(p, 4'd8, 0, "lap_neg");
        chk("lap_neg_sat", sat_cnt, 1);
        p = '0;
        p[32 +: 8] = 8'd255;
        xfer(p, 4'd8, 255, "lap_pos");
        chk("lap_pos_sat", sat_cnt, 2);

        for (int k = 0; k < 9; k++)
            wr(4'(k), 6'd4);
        wr(4'd9, 6'd4);
        xfer(fill(8'd255), 4'd8, 255, "clamp573");
        chk("clamp573_sat", sat_cnt, 3);
        pix_in = fill(8'd255);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int n = 0; n < 10 && !out_valid; n++) step();
        chk("clr_valid", out_valid, 1);
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        chk("sat_clr_prio", sat_cnt, 0);

        wr(4'd9, 6'd20);
        xfer(fill(8'd3), 4'd8, 7, "round_on");
        wr(4'd9, 6'd4);
        xfer(fill(8'd3), 4'd8, 6, "round_off");
        chk("round_sat", sat_cnt, 0);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        xfer(fill(8'd100), 4'd8, 100, "gauss_restored");

        sent = 0; got = 0; cyc = 0;
        while (got < 40 && cyc < 2000) begin
            rnd = {$urandom(), $urandom(), $urandom()};
            pix_in = rnd[71:0];
            corner_type = 4'($urandom_range(8));
            in_valid = (sent < 40) && ($urandom_range(3) != 0);
            out_ready = 1'($urandom_range(1));
            #1;
            chk("in_ready", in_ready, (!out_valid || out_ready) ? 1 : 0);
            if (in_valid && in_ready) begin
                q.push_back(model(pix_in, corner_type));
                sent++;
            end
            if (out_valid && out_ready) begin
                chk("stream", data_out, q.size() > 0 ? q.pop_front() : -1);
                got++;
            end
            hold = out_valid && !out_ready;
            hd = data_out;
            step();
            cyc++;
            if (hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", data_out, hd);
            end
        end
        chk("stream_count", got, 40);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();

        pix_in = fill(8'd100);
        corner_type = 4'd8;
        in_valid = 1'b1;
        coef_we = 1'b1;
        coef_addr = 4'd4;
        coef_wdata = 6'd0;
        step();
        coef_we = 1'b0;
        step();
        in_valid = 1'b0;
        for (int n = 0; n < 10 && !out_valid; n++) step();
        chk("wr_old_v", out_valid, 1);
        chk("wr_old", data_out, 100);
        step();
        chk("wr_new_v", out_valid, 1);
        chk("wr_new", data_out, 75);
        step();

        in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        chk("midrst_valid", out_valid, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("midrst_flush", out_valid, 0);
        end
        xfer(fill(8'd100), 4'd8, 100, "midrst_gauss");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
